// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM port arbiter.
package sdram_arb_pkg;

  // Widest word address a capture slot can hold; ports narrower than this
  // are zero-extended inside the slot.
  localparam int ARB_ADDR_MAX = 22;

  // Default number of WAIT cycles before an access is abandoned.
  localparam int ARB_TIMEOUT  = 63;

  // Width of the timeout counter.
  localparam int ARB_CNT_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  // One captured request, as latched from a requester pulse.
  typedef struct packed {
    logic                    we;
    logic [ARB_ADDR_MAX-1:0] address;
    logic [15:0]             data_write;
    logic [1:0]              wm;
  } slot_t;

endpackage

// File: rtl/sdram_bus.sv
// Single-access SDRAM controller handshake: one-cycle req, one-cycle ack.
interface sdram_bus #(
  parameter int ADDR_BITS = 22
);
  logic                 req;
  logic                 we;
  logic [ADDR_BITS-1:0] address;
  logic [15:0]          data_write;
  logic [1:0]           wm;
  logic                 ack;
  logic [15:0]          data_read;

  modport controller (
    output req, we, address, data_write, wm,
    input  ack, data_read
  );

  modport memory (
    input  req, we, address, data_write, wm,
    output ack, data_read
  );
endinterface

// File: rtl/sdram_arb_slot.sv
// Per-requester capture slot: holds the latest request until the
// scheduler grants it, and flags requests that overwrite unserved work.
module sdram_arb_slot
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_BITS = 22  // must not exceed ARB_ADDR_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [15:0]          data_write,
  input  logic [1:0]           wm,
  input  logic                 grant,    // scheduler took this slot this cycle
  input  logic                 busy,     // this port's access is on the bus
  output logic                 pending,
  output logic                 overrun,
  output slot_t                slot
);

  logic  pending_q, pending_d;
  logic  overrun_q, overrun_d;
  slot_t slot_q, slot_d;

  // Capture on req (latest wins); grant clears pending unless a new req lands.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    slot_d    = slot_q;
    if (grant) begin
      pending_d = 1'b0;
    end
    if (req) begin
      pending_d = 1'b1;
      if (pending_q || busy) begin
        overrun_d = 1'b1;
      end
      slot_d.we                         = we;
      slot_d.address                    = '0;
      slot_d.address[ADDR_BITS-1:0]     = address;
      slot_d.data_write                 = data_write;
      slot_d.wm                         = wm;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      slot_q    <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      slot_q    <= slot_d;
    end
  end

  assign pending = pending_q;
  assign overrun = overrun_q;
  assign slot    = slot_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Fixed-priority arbiter sharing one SDRAM controller port among several
// pulse-driven requesters; one access in flight, with a WAIT timeout.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_BITS = 22,
  parameter int TIMEOUT   = ARB_TIMEOUT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  sdram_bus.controller                         ram,
  input  logic [NUM_PORTS-1:0]                 req,
  input  logic [NUM_PORTS-1:0]                 we,
  input  logic [NUM_PORTS-1:0][ADDR_BITS-1:0]  address,
  input  logic [NUM_PORTS-1:0][15:0]           data_write,
  input  logic [NUM_PORTS-1:0][1:0]            wm,
  output logic [NUM_PORTS-1:0]                 ack,
  output logic [15:0]                          data_read,
  output logic [NUM_PORTS-1:0]                 overrun,
  output logic                                 timeout_err
);

  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  // Abort is decided on the last WAIT cycle so the ack lands TIMEOUT+1
  // cycles after the ISSUE cycle.
  localparam logic [ARB_CNT_BITS-1:0] CNT_LAST = ARB_CNT_BITS'(TIMEOUT - 1);

  arb_state_t                  state_q, state_d;
  logic [GW-1:0]               gnt_q, gnt_d;
  logic [ARB_CNT_BITS-1:0]     cnt_q, cnt_d;
  logic                        ram_req_q, ram_req_d;
  logic                        ram_we_q, ram_we_d;
  logic [ADDR_BITS-1:0]        ram_address_q, ram_address_d;
  logic [15:0]                 ram_data_write_q, ram_data_write_d;
  logic [1:0]                  ram_wm_q, ram_wm_d;
  logic [NUM_PORTS-1:0]        ack_q, ack_d;
  logic [15:0]                 data_read_q, data_read_d;
  logic                        timeout_err_q, timeout_err_d;

  logic [NUM_PORTS-1:0]        pending;
  logic [NUM_PORTS-1:0]        grant_stb;
  logic [NUM_PORTS-1:0]        busy;
  slot_t                       slot_v [NUM_PORTS];
  logic [GW-1:0]               sel;
  logic                        any_pending;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
      assign busy[gi] = (state_q != IDLE) && (gnt_q == GW'(gi));
      sdram_arb_slot #(.ADDR_BITS(ADDR_BITS)) u_slot (
        .clk        (clk),
        .rst        (rst),
        .req        (req[gi]),
        .we         (we[gi]),
        .address    (address[gi]),
        .data_write (data_write[gi]),
        .wm         (wm[gi]),
        .grant      (grant_stb[gi]),
        .busy       (busy[gi]),
        .pending    (pending[gi]),
        .overrun    (overrun[gi]),
        .slot       (slot_v[gi])
      );
    end
  endgenerate

  // Priority encoder: lowest pending index wins.
  always_comb begin
    sel         = '0;
    any_pending = |pending;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel = GW'(i);
      end
    end
  end

  // Scheduler: grant, issue one req pulse, then wait for ack or timeout.
  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    cnt_d            = cnt_q;
    ram_req_d        = 1'b0;
    ram_we_d         = ram_we_q;
    ram_address_d    = ram_address_q;
    ram_data_write_d = ram_data_write_q;
    ram_wm_d         = ram_wm_q;
    ack_d            = '0;
    data_read_d      = data_read_q;
    timeout_err_d    = timeout_err_q;
    grant_stb        = '0;
    unique case (state_q)
      IDLE: begin
        if (any_pending) begin
          gnt_d            = sel;
          grant_stb[sel]   = 1'b1;
          ram_we_d         = slot_v[sel].we;
          ram_address_d    = slot_v[sel].address[ADDR_BITS-1:0];
          ram_data_write_d = slot_v[sel].data_write;
          ram_wm_d         = slot_v[sel].wm;
          ram_req_d        = 1'b1;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (ram.ack) begin
          if (!ram_we_q) begin
            data_read_d = ram.data_read;
          end
          ack_d[gnt_q] = 1'b1;
          state_d      = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          ack_d[gnt_q]  = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scheduler and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      gnt_q            <= '0;
      cnt_q            <= '0;
      ram_req_q        <= 1'b0;
      ram_we_q         <= 1'b0;
      ram_address_q    <= '0;
      ram_data_write_q <= '0;
      ram_wm_q         <= '0;
      ack_q            <= '0;
      data_read_q      <= '0;
      timeout_err_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      gnt_q            <= gnt_d;
      cnt_q            <= cnt_d;
      ram_req_q        <= ram_req_d;
      ram_we_q         <= ram_we_d;
      ram_address_q    <= ram_address_d;
      ram_data_write_q <= ram_data_write_d;
      ram_wm_q         <= ram_wm_d;
      ack_q            <= ack_d;
      data_read_q      <= data_read_d;
      timeout_err_q    <= timeout_err_d;
    end
  end

  assign ram.req        = ram_req_q;
  assign ram.we         = ram_we_q;
  assign ram.address    = ram_address_q;
  assign ram.data_write = ram_data_write_q;
  assign ram.wm         = ram_wm_q;
  assign ack            = ack_q;
  assign data_read      = data_read_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: a transaction-level model predicts
// every issued access and every completion; monitors compare as they occur.
module tb_sdram_arbiter;
  localparam int NP  = 3;
  localparam int AB  = 22;
  localparam int TMO = 63;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NP-1:0]          req, we, ack, overrun;
  logic [NP-1:0][AB-1:0]  address;
  logic [NP-1:0][15:0]    data_write;
  logic [NP-1:0][1:0]     wm;
  logic [15:0]            data_read;
  logic                   timeout_err;
  logic                   mem_ack = 1'b0;
  logic [15:0]            mem_rdata = 16'h0;
  int                     cyc = 0;
  int                     checks = 0;
  int                     errors = 0;

  sdram_bus #(.ADDR_BITS(AB)) ram ();
  assign ram.ack       = mem_ack;
  assign ram.data_read = mem_rdata;

  sdram_arbiter #(.NUM_PORTS(NP), .ADDR_BITS(AB), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ram         (ram),
    .req         (req),
    .we          (we),
    .address     (address),
    .data_write  (data_write),
    .wm          (wm),
    .ack         (ack),
    .data_read   (data_read),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic we; logic [AB-1:0] addr; logic [15:0] wd; logic [1:0] wm; } iss_t;
  typedef struct { int cyc; int port; logic [15:0] dr; logic tmo; } ack_t;
  typedef struct { int lat; logic [15:0] rd; } mem_t;
  iss_t iss_q[$];
  ack_t ack_q[$];
  mem_t mem_q[$];

  // Reference model state: latest request per port, current occupancy.
  logic [NP-1:0]          m_pend = '0;
  logic [NP-1:0]          m_we;
  logic [NP-1:0][AB-1:0]  m_addr;
  logic [NP-1:0][15:0]    m_wd;
  logic [NP-1:0][1:0]     m_wm;
  int                     m_port = -1;
  int                     m_done = 0;
  logic [15:0]            m_dr = 16'h0;
  logic [NP-1:0]          m_ovr = '0;
  logic                   m_tmo = 1'b0;
  int                     dir_lat = -1;
  logic [15:0]            dir_rd = 16'h0;

  // Fields the next step() drives with its request pulses.
  logic [NP-1:0]          n_we = '0;
  logic [NP-1:0][AB-1:0]  n_addr = '0;
  logic [NP-1:0][15:0]    n_wd = '0;
  logic [NP-1:0][1:0]     n_wm = '0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // One clock of stimulus; the model advances by the same cycle.
  task automatic step(input logic [NP-1:0] rq);
    int c, g;
    mem_t m;
    iss_t is;
    ack_t a;
    @(negedge clk);
    c = cyc;
    for (int i = 0; i < NP; i++)
      if (rq[i] && (m_pend[i] || (m_port == i && c < m_done))) m_ovr[i] = 1'b1;
    if (c >= m_done && m_pend != '0) begin
      g = 0;
      for (int i = NP - 1; i >= 0; i--) if (m_pend[i]) g = i;
      if (dir_lat >= 0) begin
        m.lat = dir_lat;
        m.rd  = dir_rd;
        dir_lat = -1;
      end else begin
        m.lat = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 8));
        m.rd  = 16'($urandom);
      end
      is = '{c + 1, m_we[g], m_addr[g], m_wd[g], m_wm[g]};
      m_done = (m.lat > 0) ? (c + 2 + m.lat) : (c + 2 + TMO);
      if (m.lat > 0 && !m_we[g]) m_dr = m.rd;
      if (m.lat == 0) m_tmo = 1'b1;
      a = '{m_done, g, m_dr, (m.lat == 0)};
      iss_q.push_back(is);
      ack_q.push_back(a);
      mem_q.push_back(m);
      m_pend[g] = 1'b0;
      m_port = g;
    end
    for (int i = 0; i < NP; i++) begin
      if (rq[i]) begin
        m_pend[i] = 1'b1;
        m_we[i]   = n_we[i];
        m_addr[i] = n_addr[i];
        m_wd[i]   = n_wd[i];
        m_wm[i]   = n_wm[i];
      end
    end
    req        = rq;
    we         = n_we;
    address    = n_addr;
    data_write = n_wd;
    wm         = n_wm;
  endtask

  // Idle until the model has nothing outstanding, then settle the sticky flags.
  task automatic drain();
    int n;
    n = 0;
    while ((m_pend != '0 || cyc < m_done + 2) && n < 400) begin
      step('0);
      n++;
    end
    chk("drain_bound", 64'(n < 400), 64'd1);
    chk("issue_queue_left", 64'(iss_q.size()), 64'd0);
    chk("ack_queue_left", 64'(ack_q.size()), 64'd0);
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("timeout_err", 64'(timeout_err), 64'(m_tmo));
  endtask

  // Memory responder: acks each issued access after the model-chosen latency.
  always begin
    mem_t m;
    @(negedge clk);
    if (!rst && ram.req && mem_q.size() > 0) begin
      m = mem_q.pop_front();
      if (m.lat > 0) begin
        repeat (m.lat) @(negedge clk);
        mem_rdata = m.rd;
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
      end
    end
  end

  // Monitor: every bus issue and every completion is popped and compared.
  iss_t mon_i;
  ack_t mon_a;
  always @(negedge clk) begin
    if (!rst) begin
      if (ram.req) begin
        if (iss_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got ram.req=1 addr %h, required no issue (cycle %0d)", ram.address, cyc);
        end else begin
          mon_i = iss_q.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(mon_i.cyc));
          chk("issue_addr", 64'(ram.address), 64'(mon_i.addr));
          chk("issue_we_wm_data", 64'({ram.we, ram.wm, ram.data_write}),
              64'({mon_i.we, mon_i.wm, mon_i.wd}));
          $display("issue addr %h we %0d wm %b wdata %h cycle %0d",
                   ram.address, ram.we, ram.wm, ram.data_write, cyc);
        end
      end
      if (ack != '0) begin
        chk("ack_onehot", 64'($onehot(ack)), 64'd1);
        if (ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack=%b, required none (cycle %0d)", ack, cyc);
        end else begin
          mon_a = ack_q.pop_front();
          chk("ack_port", 64'(ack), 64'(1 << mon_a.port));
          chk("ack_cycle", 64'(cyc), 64'(mon_a.cyc));
          chk("data_read", 64'(data_read), 64'(mon_a.dr));
          if (mon_a.tmo) chk("timeout_err_at_abort", 64'(timeout_err), 64'd1);
          $display("ack port %0d data_read %h timeout %0d cycle %0d",
                   mon_a.port, data_read, mon_a.tmo, cyc);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ram_req"}, 64'(ram.req), 64'd0);
    chk({tag, "_ram_fields"}, 64'({ram.we, ram.address, ram.data_write, ram.wm}), 64'd0);
    chk({tag, "_ack"}, 64'(ack), 64'd0);
    chk({tag, "_data_read"}, 64'(data_read), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    chk({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
  endtask

  task automatic model_reset();
    iss_q.delete();
    ack_q.delete();
    mem_q.delete();
    m_pend = '0;
    m_port = -1;
    m_done = 0;
    m_dr   = 16'h0;
    m_ovr  = '0;
    m_tmo  = 1'b0;
    dir_lat = -1;
  endtask

  initial begin
    rst = 1'b1;
    req = '0; we = '0; address = '0; data_write = '0; wm = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    step('0);

    // Single read from port 1.
    n_we[1] = 1'b0; n_addr[1] = 22'h01234;
    dir_lat = 5; dir_rd = 16'hBEEF;
    step(3'b010);
    drain();
    chk("single_read_data", 64'(data_read), 64'hBEEF);

    // Contention between ports 0 and 2.
    n_we = 3'b000; n_addr[0] = 22'h00AAA; n_addr[2] = 22'h00CCC;
    step(3'b101);
    drain();

    // Overrun: port 2 fires twice while port 0 is in flight.
    n_addr[0] = 22'h00010;
    dir_lat = 8; dir_rd = 16'h1111;
    step(3'b001);
    step('0);
    n_addr[2] = 22'h00100;
    step(3'b100);
    n_addr[2] = 22'h00200;
    step(3'b100);
    drain();
    chk("overrun_port2", 64'(overrun[2]), 64'd1);

    // Write from port 2.
    n_we[2] = 1'b1; n_wd[2] = 16'h5A5A; n_wm[2] = 2'b01; n_addr[2] = 22'h3FFFF;
    step(3'b100);
    drain();

    // Timeout on port 0, then port 1 served normally.
    n_we = '0; n_addr[0] = 22'h00777; n_addr[1] = 22'h00888;
    dir_lat = 0;
    step(3'b001);
    step(3'b010);
    drain();
    chk("timeout_sticky", 64'(timeout_err), 64'd1);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      logic [NP-1:0] rq;
      for (int i = 0; i < NP; i++) begin
        rq[i]     = ($urandom_range(0, 9) == 0);
        n_we[i]   = 1'($urandom_range(0, 1));
        n_addr[i] = AB'($urandom);
        n_wd[i]   = 16'($urandom);
        n_wm[i]   = 2'($urandom_range(0, 3));
      end
      step(rq);
    end
    drain();

    // Reset in the middle of an access that would otherwise time out.
    n_we = '0; n_addr[1] = 22'h02468;
    dir_lat = 0;
    step(3'b010);
    repeat (6) step('0);
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (80) step('0);
    chk("no_ack_after_reset", 64'(ack_q.size()), 64'd0);

    // Fresh request after reset.
    n_addr[1] = 22'h01357;
    dir_lat = 3; dir_rd = 16'hC0DE;
    step(3'b010);
    drain();
    chk("post_reset_data", 64'(data_read), 64'hC0DE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM controller port among several byte-/word-level requesters (PRG ROM/RAM path, CHR path, MCU loader) so each requester can fire one-cycle read/write pulses without knowing about the others. Each port captures its request, a fixed-priority scheduler issues one access at a time on `sdram_bus.controller`, and completion is routed back as a per-port `ack` with the read word. It sits between the mapper-side memory front-ends and the SDRAM controller.

## Interface
Parameters:
- `NUM_PORTS`, 3, number of requesters; port 0 has highest priority.
- `ADDR_BITS`, 22, word address width (SDRAM word space).
- `TIMEOUT`, 63, max cycles to wait for `ram.ack` before abort; 8-bit counter.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `ram`  `sdram_bus.controller`  —  downstream port: drives `req`, `we`, `address`, `data_write`, `wm`; samples `ack`, `data_read`.
- `req`  in  [NUM_PORTS]  one-cycle request pulse per port.
- `we`  in  [NUM_PORTS]  1 = write, 0 = read; sampled with `req`.
- `address`  in  [NUM_PORTS][ADDR_BITS]  word address; sampled with `req`.
- `data_write`  in  [NUM_PORTS][16]  write word; sampled with `req`.
- `wm`  in  [NUM_PORTS][2]  byte write mask (bit1 = [15:8]); sampled with `req`.
- `ack`  out  [NUM_PORTS]  one-cycle completion pulse to the owning port.
- `data_read`  out  16  read word, valid in the `ack` cycle and held until next completion.
- `overrun`  out  [NUM_PORTS]  sticky: a `req` arrived while that port was still pending/in flight.
- `timeout_err`  out  1  sticky: an access was aborted by timeout.

## Operation
- Per-port slot: on `req[i]`, latch `we/address/data_write/wm` and set `pending[i]`. If `pending[i]` already set, or port `i` is in flight, new request overwrites the slot (latest wins) and sets `overrun[i]`.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any `pending`, grant lowest index, copy slot to `ram.*`, clear `pending[g]`, go ISSUE.
  - ISSUE: `ram.req`=1 for exactly this cycle, go WAIT, start timeout counter at 0.
  - WAIT: on `ram.ack`: register `ram.data_read` into `data_read`, pulse `ack[g]`, go IDLE. If counter reaches `TIMEOUT` without ack: pulse `ack[g]` with `data_read` unchanged, set `timeout_err`, go IDLE.
- Only one access in flight; `ram.ack` outside WAIT is ignored.
- `req[i]` in the same cycle as `ack[i]` is accepted as a fresh pending request, no overrun.
- Write completions also pulse `ack`; `data_read` is not updated on writes.
- Sticky flags clear only on `rst`.
- Reset values: `ram.req`=0, `ram.we`=0, `ram.address`=0, `ram.data_write`=0, `ram.wm`=0, `ack`=0, `data_read`=0, `overrun`=0, `timeout_err`=0, `pending`=0, state IDLE. Reset mid-access abandons it: no `ack` is produced.

## Timing
- `req[i]` at cycle t → `pending[i]` at t+1 → grant in IDLE at t+1 → `ram.req`=1 at t+2 (idle arbiter).
- `ram.ack` at cycle a → `ack[g]` and `data_read` valid at a+1; next grant evaluated at a+1, next `ram.req` at a+2 earliest.
- Minimum issue-to-issue spacing: 3 cycles + controller latency.
- Timeout abort: `ack[g]` at ISSUE+1+TIMEOUT.
- All outputs registered; no combinational path from `req` or `ram.ack` to any output.

## Structure
- Package `sdram_arb_pkg`: `arb_state_t` enum {IDLE, ISSUE, WAIT}, `slot_t` struct {we, address, data_write, wm}, default `TIMEOUT`.
- Sub-module `sdram_arb_slot`: one per port, capture register + `pending`/`overrun` logic, cleared by grant strobe.
- Top holds priority encoder, FSM, timeout counter, response routing.

## Test plan
- Single read: port 1 `req`, address 0x01234; model acks 5 cycles after `ram.req` with 0xBEEF → `ram.req` at t+2, `ack[1]` once, `data_read`=0xBEEF, other acks 0.
- Contention: ports 0 and 2 pulse `req` same cycle → port 0 issued first, port 2 issued after `ack[0]`; `overrun`=0.
- Overrun: port 2 pulses twice (0x100 then 0x200) while port 0 in flight → one access to 0x200 for port 2, `overrun[2]`=1.
- Write: port 2 write 0x5A5A, `wm`=2'b01 → `ram.we`=1, `ram.wm`=01, `ack[2]` pulses, `data_read` unchanged.
- Timeout: model never acks → `ack[g]` at ISSUE+64, `timeout_err`=1, next pending port then served normally.
- Reset in WAIT: assert `rst` mid-access → all outputs zero immediately, no `ack`; new request after release served normally.
